// File: rtl/instr_sequencer_if.sv
// Host/processor-facing signal bundle of the instruction sequencer.
// The sequencer uses the slave modport; the host/processor side uses master.
interface instr_sequencer_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              LoadEn;
    logic [ADDR_W-1:0] LoadAddr;
    logic [15:0]       LoadData;
    logic              Start;
    logic [ADDR_W:0]   Count;
    logic              Abort;
    logic              Done;
    logic [15:0]       DIN;
    logic              Run;
    logic              Busy;
    logic              Finished;
    logic              Error;
    logic [ADDR_W-1:0] PC;

    modport master (
        output LoadEn, LoadAddr, LoadData, Start, Count, Abort, Done,
        input  DIN, Run, Busy, Finished, Error, PC
    );

    modport slave (
        input  LoadEn, LoadAddr, LoadData, Start, Count, Abort, Done,
        output DIN, Run, Busy, Finished, Error, PC
    );
endinterface

// File: rtl/instr_sequencer.sv
// Issues a loaded program to the processor over DIN/Run/Done, one word per Done,
// with a watchdog that parks in ERROR when the processor stops answering.
module instr_sequencer #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             Clock,
    input  logic             Resetn,
    instr_sequencer_if.slave bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned TMR_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_SAT   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] din_q,   din_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              run_q,   run_d;
    logic              busy_q,  busy_d;
    logic              fin_q,   fin_d;
    logic              err_q,   err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] pc_inc;
    logic [TMR_W-1:0]  timer_inc;
    logic              last_instr;
    logic              wd_fire;
    logic [CNT_W-1:0]  count_clamped;
    logic [DATA_W-1:0] first_word;

    // Program memory: host writes only while idle, never during reset
    assign mem_we = Resetn && bus.LoadEn && (state_q == S_IDLE);

    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[bus.LoadAddr] <= bus.LoadData;
        end
    end

    assign pc_inc        = pc_q + 1'b1;
    assign timer_inc     = (timer_q == TMR_SAT) ? timer_q : timer_q + 1'b1;
    assign last_instr    = ({1'b0, pc_q} == (count_q - 1'b1));
    assign wd_fire       = (TIMEOUT != 0) && (timer_inc == TMR_LIMIT);
    assign count_clamped = (bus.Count > CNT_MAX) ? CNT_MAX : bus.Count;
    // A same-cycle write to address 0 is forwarded so the new word is issued
    assign first_word    = (bus.LoadEn && (bus.LoadAddr == '0)) ? bus.LoadData : mem[0];

    // State register
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        pc_d    = pc_q;
        count_d = count_q;
        timer_d = timer_q;
        run_d   = 1'b0;
        fin_d   = 1'b0;
        err_d   = err_q;

        if (bus.Abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        if (bus.Count == '0) begin
                            fin_d = 1'b1;
                        end else begin
                            count_d = count_clamped;
                            pc_d    = '0;
                            din_d   = first_word;
                            err_d   = 1'b0;
                            timer_d = '0;
                            run_d   = 1'b1;
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    timer_d = timer_inc;
                    // Done beats a watchdog expiry on the same edge
                    if (bus.Done) begin
                        if (last_instr) begin
                            fin_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            pc_d    = pc_inc;
                            din_d   = mem[pc_inc];
                            run_d   = 1'b1;
                            state_d = S_ISSUE;
                        end
                    end else if (wd_fire) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end
                end
                S_ERROR: begin
                    state_d = S_ERROR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    end

    // Datapath and output registers
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            din_q   <= '0;
            pc_q    <= '0;
            count_q <= '0;
            timer_q <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            din_q   <= din_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            timer_q <= timer_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
        end
    end

    assign bus.DIN      = din_q;
    assign bus.PC       = pc_q;
    assign bus.Run      = run_q;
    assign bus.Busy     = busy_q;
    assign bus.Finished = fin_q;
    assign bus.Error    = err_q;
endmodule
